// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
//
// Watches a CPU run. It counts elapsed cycles and per-channel event strobes
// until the CPU halts or a cycle limit expires. A halt captures the CPU's
// return value as the exit code. After a halt, an optional drain period lets
// in-flight events settle before the run is declared complete. Once complete,
// every result is frozen until reset.
//
// Parameters
//   CNT_W        cycle counter width
//   MAX_CYCLES   timeout limit in cycles (1 .. 2^CNT_W-1)
//   DRAIN_CYCLES cycles spent between halt capture and completion (0 .. 255)
//   N_EVT        number of event channels (1 .. 8)
//   EVT_W        per-channel event counter width
//   RET_W        captured exit-code width (1 .. 16)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   halt       in   CPU halt indication
//   ret_val    in   CPU return value, low RET_W bits captured on halt
//   evt        in   per-channel event strobes, one count per high cycle
//   done       out  run has ended (halt or timeout)
//   timed_out  out  run ended by timeout
//   exit_code  out  captured return value
//   cycles     out  elapsed cycle count (saturating)
//   evt_count  out  channel i count at [i*EVT_W +: EVT_W] (saturating)
//
// Build option
//   RUN_MONITOR_SIM_PRINT_EN  when defined, a simulation-only block reports
//   the outcome and per-channel counts on the edge entering DONE, then calls
//   $finish. Outputs are identical with or without it.
// -----------------------------------------------------------------------------
module run_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 500000,
  parameter int unsigned DRAIN_CYCLES = 0,
  parameter int unsigned N_EVT        = 2,
  parameter int unsigned EVT_W        = 32,
  parameter int unsigned RET_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic [15:0]            ret_val,
  input  logic [N_EVT-1:0]       evt,
  output logic                   done,
  output logic                   timed_out,
  output logic [RET_W-1:0]       exit_code,
  output logic [CNT_W-1:0]       cycles,
  output logic [N_EVT*EVT_W-1:0] evt_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CYC_SAT    = '1;
  localparam logic [EVT_W-1:0] EVT_SAT    = '1;
  localparam logic [CNT_W-1:0] MAX_LIM    = CNT_W'(MAX_CYCLES);
  localparam logic [7:0]       DRAIN_INIT = 8'(DRAIN_CYCLES);

  state_t           state;
  state_t           state_next;
  logic [7:0]       drain_cnt;
  logic             active;       // counting phase: RUN or DRAIN
  logic             capture;      // accepted halt this cycle
  logic             timeout_hit;  // limit reached without halt this cycle
  logic             cyc_inc;
  logic [EVT_W-1:0] evt_cnt      [N_EVT];
  logic [EVT_W-1:0] evt_cnt_next [N_EVT];

  // Upper ret_val bits are intentionally ignored when RET_W < 16.
  logic unused_ret;
  assign unused_ret = ^ret_val;

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_next  = state;
    active      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      ST_RUN: begin
        active = 1'b1;
        // Halt is tested first so a halt on the limit cycle is a clean exit.
        if (halt) begin
          capture    = 1'b1;
          state_next = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_DONE;
        end else if (cycles == MAX_LIM) begin
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end
      end
      ST_DRAIN: begin
        active = 1'b1;
        // Leave on the edge where the down-counter reaches zero.
        if (drain_cnt <= 8'd1) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_RUN;
    endcase
  end

  // The timeout edge leaves the count at the limit rather than one past it.
  assign cyc_inc = active && !timeout_hit && (cycles != CYC_SAT);

  always_comb begin
    for (int i = 0; i < N_EVT; i++) begin
      evt_cnt_next[i] = evt_cnt[i];
      if (active && evt[i] && (evt_cnt[i] != EVT_SAT))
        evt_cnt_next[i] = evt_cnt[i] + EVT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state     <= ST_RUN;
      done      <= 1'b0;
      timed_out <= 1'b0;
      exit_code <= '0;
      cycles    <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      done  <= (state_next == ST_DONE);
      if (cyc_inc)     cycles    <= cycles + CNT_W'(1);
      if (capture)     exit_code <= ret_val[RET_W-1:0];
      if (timeout_hit) timed_out <= 1'b1;
      if (capture)
        drain_cnt <= DRAIN_INIT;
      else if ((state == ST_DRAIN) && (drain_cnt != 8'd0))
        drain_cnt <= drain_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is a bank of flops feeding outputs, not a RAM,
    // so each entry is reset explicitly to give defined results after rst.
    if (rst) begin
      for (int i = 0; i < N_EVT; i++) evt_cnt[i] <= '0;
    end else begin
      evt_cnt <= evt_cnt_next;
    end
  end

  for (genvar g = 0; g < N_EVT; g++) begin : g_evt_out
    assign evt_count[g*EVT_W +: EVT_W] = evt_cnt[g];
  end

`ifdef RUN_MONITOR_SIM_PRINT_EN
  // Report using the values that are being registered on this edge.
  always @(posedge clk) begin
    if (!rst && (state != ST_DONE) && (state_next == ST_DONE)) begin
      for (int i = 0; i < N_EVT; i++)
        $display("evt[%0d] count %0d", i, evt_cnt_next[i]);
      if (timeout_hit)
        $display("ran for %0d cycles", MAX_CYCLES);
      else
        $display("Finished with %0d", capture ? ret_val[RET_W-1:0] : exit_code);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_run_monitor
//
// Four run_monitor instances with different parameter sets, each driven by
// its own reset/halt/ret_val/evt. Each scenario pushes its expected run
// result (edge of done, timed_out, exit_code, cycles, event counts) into a
// per-instance queue; a monitor pops it when that instance's done rises and
// keeps comparing against it while done stays high, so frozen results are
// also checked.
//
//   u0  defaults
//   u1  MAX_CYCLES=50, DRAIN_CYCLES=3, EVT_W=4
//   u2  MAX_CYCLES=20, RET_W=16
//   u3  CNT_W=4, MAX_CYCLES=15, DRAIN_CYCLES=5, N_EVT=1, RET_W=4
// -----------------------------------------------------------------------------
module tb_run_monitor;

  typedef struct packed {
    logic [31:0] tick;
    logic        to;
    logic [15:0] ec;
    logic [31:0] cy;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  logic        clk;
  logic [3:0]  rst;
  logic [3:0]  halt;
  logic [15:0] rv [4];
  logic [1:0]  ev [4];

  logic        done_v [4];
  logic        to_v   [4];
  logic [15:0] ec_v   [4];
  logic [31:0] cy_v   [4];
  logic [31:0] e0_v   [4];
  logic [31:0] e1_v   [4];

  logic [7:0]  ec0;
  logic [31:0] cy0;
  logic [63:0] evc0;
  logic [7:0]  ec1;
  logic [31:0] cy1;
  logic [7:0]  evc1;
  logic [15:0] ec2;
  logic [31:0] cy2;
  logic [63:0] evc2;
  logic [3:0]  ec3;
  logic [3:0]  cy3;
  logic [31:0] evc3;

  exp_t        sbq [4][$];
  exp_t        held [4];
  logic        done_prev [4];
  int unsigned tick;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tick <= tick + 1;

  run_monitor u0 (
    .clk(clk), .rst(rst[0]), .halt(halt[0]), .ret_val(rv[0]), .evt(ev[0]),
    .done(done_v[0]), .timed_out(to_v[0]), .exit_code(ec0), .cycles(cy0),
    .evt_count(evc0)
  );

  run_monitor #(.MAX_CYCLES(50), .DRAIN_CYCLES(3), .EVT_W(4)) u1 (
    .clk(clk), .rst(rst[1]), .halt(halt[1]), .ret_val(rv[1]), .evt(ev[1]),
    .done(done_v[1]), .timed_out(to_v[1]), .exit_code(ec1), .cycles(cy1),
    .evt_count(evc1)
  );

  run_monitor #(.MAX_CYCLES(20), .RET_W(16)) u2 (
    .clk(clk), .rst(rst[2]), .halt(halt[2]), .ret_val(rv[2]), .evt(ev[2]),
    .done(done_v[2]), .timed_out(to_v[2]), .exit_code(ec2), .cycles(cy2),
    .evt_count(evc2)
  );

  run_monitor #(.CNT_W(4), .MAX_CYCLES(15), .DRAIN_CYCLES(5), .N_EVT(1),
                .RET_W(4)) u3 (
    .clk(clk), .rst(rst[3]), .halt(halt[3]), .ret_val(rv[3]), .evt(ev[3][0]),
    .done(done_v[3]), .timed_out(to_v[3]), .exit_code(ec3), .cycles(cy3),
    .evt_count(evc3)
  );

  assign ec_v[0] = {8'h00, ec0};
  assign cy_v[0] = cy0;
  assign e0_v[0] = evc0[31:0];
  assign e1_v[0] = evc0[63:32];
  assign ec_v[1] = {8'h00, ec1};
  assign cy_v[1] = cy1;
  assign e0_v[1] = {28'h0, evc1[3:0]};
  assign e1_v[1] = {28'h0, evc1[7:4]};
  assign ec_v[2] = ec2;
  assign cy_v[2] = cy2;
  assign e0_v[2] = evc2[31:0];
  assign e1_v[2] = evc2[63:32];
  assign ec_v[3] = {12'h000, ec3};
  assign cy_v[3] = {28'h0, cy3};
  assign e0_v[3] = evc3;
  assign e1_v[3] = 32'h0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input int unsigned tk, input logic to,
                      input logic [15:0] ec, input logic [31:0] cy,
                      input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    e.tick = tk;
    e.to   = to;
    e.ec   = ec;
    e.cy   = cy;
    e.e0   = e0;
    e.e1   = e1;
    sbq[i].push_back(e);
  endtask

  // Pulse reset for one edge; t0 is the tick at the release negedge, so
  // after k further edges the instance should show cycles == k.
  task automatic start(input int i, output int unsigned t0);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    t0 = tick;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input int i, input string tag);
    check($sformatf("u%0d_%s_done", i, tag), {31'h0, done_v[i]}, 32'h0);
    check($sformatf("u%0d_%s_timed_out", i, tag), {31'h0, to_v[i]}, 32'h0);
    check($sformatf("u%0d_%s_exit_code", i, tag), {16'h0, ec_v[i]}, 32'h0);
    check($sformatf("u%0d_%s_cycles", i, tag), cy_v[i], 32'h0);
    check($sformatf("u%0d_%s_evt0", i, tag), e0_v[i], 32'h0);
    check($sformatf("u%0d_%s_evt1", i, tag), e1_v[i], 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pop on done rising, keep comparing while done holds
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] && !done_prev[i]) begin
        if (sbq[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL u%0d_done_unexpected: got done=1, required done=0", i);
        end else begin
          held[i] = sbq[i].pop_front();
          check($sformatf("u%0d_done_tick", i), tick, held[i].tick);
          check($sformatf("u%0d_timed_out", i), {31'h0, to_v[i]}, {31'h0, held[i].to});
          check($sformatf("u%0d_exit_code", i), {16'h0, ec_v[i]}, {16'h0, held[i].ec});
          check($sformatf("u%0d_cycles", i), cy_v[i], held[i].cy);
          check($sformatf("u%0d_evt0", i), e0_v[i], held[i].e0);
          check($sformatf("u%0d_evt1", i), e1_v[i], held[i].e1);
        end
      end else if (done_v[i]) begin
        check($sformatf("u%0d_frozen_timed_out", i), {31'h0, to_v[i]}, {31'h0, held[i].to});
        check($sformatf("u%0d_frozen_exit_code", i), {16'h0, ec_v[i]}, {16'h0, held[i].ec});
        check($sformatf("u%0d_frozen_cycles", i), cy_v[i], held[i].cy);
        check($sformatf("u%0d_frozen_evt0", i), e0_v[i], held[i].e0);
        check($sformatf("u%0d_frozen_evt1", i), e1_v[i], held[i].e1);
      end
      done_prev[i] = done_v[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned t0;
    n_checks = 0;
    n_fail   = 0;
    tick     = 0;
    rst      = 4'hF;
    halt     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      rv[i]        = 16'h0;
      ev[i]        = 2'b00;
      done_prev[i] = 1'b0;
    end
    step(3);
    for (int i = 0; i < 4; i++) check_zero(i, "reset");

    // u0: halt at cycles=100 -> done next edge, cycles 101, exit_code 0x34.
    // evt0 high every cycle up to and including the halt cycle, evt1 only
    // on the halt cycle.
    start(0, t0);
    push(0, t0 + 101, 1'b0, 16'h0034, 101, 101, 1);
    ev[0] = 2'b01;
    step(100);
    halt[0] = 1'b1; rv[0] = 16'h1234; ev[0] = 2'b11;
    step(1);
    // Activity after completion must not disturb frozen results.
    halt[0] = 1'b1; rv[0] = 16'hFFFF; ev[0] = 2'b11;
    step(3);
    halt[0] = 1'b0; rv[0] = 16'h0; ev[0] = 2'b00;

    // u1: timeout at 50 plus 4-bit event saturation (ch0 20 -> 15, ch1 10).
    start(1, t0);
    push(1, t0 + 51, 1'b1, 16'h0000, 50, 15, 10);
    for (int k = 0; k < 20; k++) begin
      ev[1] = {(k % 2 == 0), 1'b1};
      step(1);
    end
    ev[1] = 2'b00;
    step(31);
    ev[1] = 2'b11;
    step(3);
    ev[1] = 2'b00;

    // u1: halt at cycles=10 (ret 7), second halt in DRAIN (ret 9) ignored;
    // DONE three edges after the halt edge with cycles 14.
    start(1, t0);
    push(1, t0 + 14, 1'b0, 16'h0007, 14, 0, 2);
    step(10);
    halt[1] = 1'b1; rv[1] = 16'd7; ev[1] = 2'b10;
    step(1);
    halt[1] = 1'b1; rv[1] = 16'd9; ev[1] = 2'b10;
    step(1);
    halt[1] = 1'b0; rv[1] = 16'd0; ev[1] = 2'b00;
    step(4);

    // u1: reset while in DRAIN with halt high; halt discarded, run restarts.
    start(1, t0);
    step(5);
    halt[1] = 1'b1; rv[1] = 16'h0055;
    step(1);
    rst[1] = 1'b1; halt[1] = 1'b1; rv[1] = 16'h0066; ev[1] = 2'b11;
    step(1);
    check_zero(1, "rst_in_drain");
    rst[1] = 1'b0; halt[1] = 1'b0; rv[1] = 16'h0; ev[1] = 2'b00;
    t0 = tick;
    push(1, t0 + 6, 1'b0, 16'h0021, 6, 0, 0);
    step(2);
    halt[1] = 1'b1; rv[1] = 16'h0021;
    step(1);
    halt[1] = 1'b0; rv[1] = 16'h0;
    step(5);

    // u2: halt exactly on the limit cycle wins over timeout; simultaneous
    // strobes on both channels all counted.
    start(2, t0);
    push(2, t0 + 21, 1'b0, 16'hBEEF, 21, 5, 5);
    ev[2] = 2'b11;
    step(5);
    ev[2] = 2'b00;
    step(15);
    halt[2] = 1'b1; rv[2] = 16'hBEEF;
    step(1);
    halt[2] = 1'b0; rv[2] = 16'h0;
    step(2);

    // u2: plain timeout at 20; cycles held at the limit.
    start(2, t0);
    push(2, t0 + 21, 1'b1, 16'h0000, 20, 0, 0);
    step(21);
    halt[2] = 1'b1; rv[2] = 16'h1111;
    step(3);
    halt[2] = 1'b0; rv[2] = 16'h0;

    // u3: 4-bit cycle counter saturates at 15 during a 5-cycle drain;
    // exit_code keeps the low 4 bits of ret_val.
    start(3, t0);
    push(3, t0 + 20, 1'b0, 16'h000A, 15, 20, 0);
    ev[3] = 2'b01;
    step(14);
    halt[3] = 1'b1; rv[3] = 16'h003A;
    step(1);
    halt[3] = 1'b0; rv[3] = 16'h0;
    step(8);
    ev[3] = 2'b00;

    step(5);
    for (int i = 0; i < 4; i++)
      check($sformatf("u%0d_pending_results", i), sbq[i].size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
